// File: rtl/ray_bbox_scan_pkg.sv
// Shared fixed-point vector, box and scan-result types for the ray/box scan path.
package ray_bbox_scan_pkg;

    localparam int FIX_W  = 28;
    localparam int FRAC_W = 16;

    typedef logic signed [FIX_W-1:0] fix_t;

    typedef struct packed {
        fix_t x;
        fix_t y;
        fix_t z;
    } vec3_t;

    typedef struct packed {
        fix_t x;
        fix_t y;
    } vec2_t;

    typedef struct packed {
        vec3_t bmin;
        vec3_t bmax;
    } bbox_t;

    localparam fix_t  INFINITY_28     = 28'sh7FF_FFFF;
    localparam fix_t  NEG_INFINITY_28 = -28'sh7FF_FFFF;
    localparam vec3_t point_default   = '0;
    // Empty interval: reported as the range of a ray that hit nothing.
    localparam vec2_t range_default   = '{x: INFINITY_28, y: NEG_INFINITY_28};
    localparam bbox_t bbox_default    = '{bmin: point_default, bmax: point_default};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} scan_state_e;

    // Fixed-width result view for downstream stages; wide enough for any table depth up to 256.
    localparam int SCAN_IDX_W = 8;

    typedef struct packed {
        logic                  hit;
        logic [SCAN_IDX_W-1:0] box_idx;
        vec2_t                 t_range;
        logic [SCAN_IDX_W:0]   hit_count;
    } scan_result_t;

    localparam scan_result_t scan_result_default =
        '{hit: 1'b0, box_idx: '0, t_range: range_default, hit_count: '0};

endpackage

// File: rtl/ray_bbox_intersect.sv
// Three-stage pipelined slab test of one ray against one axis-aligned box.
module ray_bbox_intersect
    import ray_bbox_scan_pkg::*;
(
    input  logic  clk,
    input  vec3_t ray_orig,
    input  vec3_t ray_inv_dir,
    input  bbox_t box,
    input  vec2_t prev_range,
    output logic  hit,
    output vec2_t range_out
);

    localparam int PROD_W = 2 * FIX_W + 1;
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(INFINITY_28);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(NEG_INFINITY_28);

    // Drop fraction bits of a product and clamp to the representable +/- infinity.
    function automatic fix_t sat_fix(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] s;
        s = prod >>> FRAC_W;
        if (s > SAT_HI)      return INFINITY_28;
        else if (s < SAT_LO) return NEG_INFINITY_28;
        else                 return s[FIX_W-1:0];
    endfunction

    fix_t org [3];
    fix_t inv [3];
    fix_t bmn [3];
    fix_t bmx [3];

    // Per-axis array view of the vector inputs.
    always_comb begin
        org = '{ray_orig.x, ray_orig.y, ray_orig.z};
        inv = '{ray_inv_dir.x, ray_inv_dir.y, ray_inv_dir.z};
        bmn = '{box.bmin.x, box.bmin.y, box.bmin.z};
        bmx = '{box.bmax.x, box.bmax.y, box.bmax.z};
    end

    logic signed [FIX_W:0] dmn_p0 [3];
    logic signed [FIX_W:0] dmx_p0 [3];
    fix_t                  inv_p0 [3];
    vec2_t                 prev_p0;

    // Stage 0: slab-plane offsets from the origin.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            dmn_p0[k] <= (FIX_W+1)'(bmn[k]) - (FIX_W+1)'(org[k]);
            dmx_p0[k] <= (FIX_W+1)'(bmx[k]) - (FIX_W+1)'(org[k]);
            inv_p0[k] <= inv[k];
        end
        prev_p0 <= prev_range;
    end

    fix_t ta [3];
    fix_t tb [3];

    // Saturated slab entry/exit distances.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ta[k] = sat_fix(PROD_W'(dmn_p0[k]) * PROD_W'(inv_p0[k]));
            tb[k] = sat_fix(PROD_W'(dmx_p0[k]) * PROD_W'(inv_p0[k]));
        end
    end

    fix_t  tlo_p1 [3];
    fix_t  thi_p1 [3];
    vec2_t prev_p1;

    // Stage 1: order each slab's distances so negative directions work.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            tlo_p1[k] <= (ta[k] < tb[k]) ? ta[k] : tb[k];
            thi_p1[k] <= (ta[k] < tb[k]) ? tb[k] : ta[k];
        end
        prev_p1 <= prev_p0;
    end

    fix_t t_near;
    fix_t t_far;

    // Intersect the three slabs with the incoming range.
    always_comb begin
        t_near = prev_p1.x;
        t_far  = prev_p1.y;
        for (int k = 0; k < 3; k++) begin
            if (tlo_p1[k] > t_near) t_near = tlo_p1[k];
            if (thi_p1[k] < t_far)  t_far  = thi_p1[k];
        end
    end

    // Stage 2: registered hit flag and clipped range.
    always_ff @(posedge clk) begin
        hit       <= (t_near <= t_far);
        range_out <= '{x: t_near, y: t_far};
    end

endmodule

// File: rtl/ray_bbox_scan_table.sv
// Bounding-box table: one write port, one combinational read port.
module ray_bbox_scan_table
    import ray_bbox_scan_pkg::*;
#(
    parameter int NUM_BOXES = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bbox_t            wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output bbox_t            rd_data
);

    bbox_t entry_q [NUM_BOXES];

    // Entries clear to degenerate point boxes on reset; qualified writes update one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BOXES; i++) entry_q[i] <= bbox_default;
        end else if (wr_en) begin
            entry_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = entry_q[rd_idx];

endmodule

// File: rtl/ray_bbox_scan.sv
// Streams one ray against the box table through one intersect unit and reports the nearest hit.
module ray_bbox_scan
    import ray_bbox_scan_pkg::*;
#(
    parameter int  NUM_BOXES = 8,
    parameter int  ISECT_LAT = 3,
    localparam int IDX_W     = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             ray_valid,
    output logic             ray_ready,
    input  vec3_t            ray_orig,
    input  vec3_t            ray_inv_dir,
    input  vec2_t            ray_t_range,
    input  logic [IDX_W:0]   ray_num_boxes,
    input  logic             box_wr_en,
    input  logic [IDX_W-1:0] box_wr_idx,
    input  bbox_t            box_wr_data,
    output logic             box_wr_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_box_idx,
    output vec2_t            res_range,
    output logic [IDX_W:0]   res_hit_count
);

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_BOXES);
    localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

    scan_state_e state_q, state_d;

    logic             accept, wr_accept, issue_last, ret_valid, ret_last, isect_hit;
    logic [IDX_W:0]   n_eff;
    logic [IDX_W-1:0] ret_tag;
    vec2_t            isect_range;
    bbox_t            rd_box;

    vec3_t            orig_q, inv_q;
    vec2_t            trange_q;
    logic [IDX_W:0]   count_q;
    logic [IDX_W-1:0] issue_idx_q;
    logic [ISECT_LAT-1:0] vld_q;
    logic [IDX_W-1:0] tag_q [ISECT_LAT];

    logic             best_hit_q, nb_hit;
    logic [IDX_W-1:0] best_idx_q, nb_idx;
    vec2_t            best_range_q, nb_range;
    logic [IDX_W:0]   hit_cnt_q, nb_cnt;

    assign ray_ready    = (state_q == IDLE);
    assign box_wr_ready = (state_q == IDLE);

    // Handshake qualification and issue/return bookkeeping.
    always_comb begin
        accept     = ray_valid && (state_q == IDLE);
        wr_accept  = box_wr_en && (state_q == IDLE) && ({1'b0, box_wr_idx} < MAX_CNT);
        n_eff      = (ray_num_boxes > MAX_CNT) ? MAX_CNT : ray_num_boxes;
        issue_last = (state_q == ISSUE) && ({1'b0, issue_idx_q} == count_q - ONE);
        ret_valid  = vld_q[ISECT_LAT-1];
        ret_tag    = tag_q[ISECT_LAT-1];
        ret_last   = ret_valid && ({1'b0, ret_tag} == count_q - ONE);
    end

    // Nearest-hit reduction; strict compare keeps the lower index on ties.
    always_comb begin
        nb_hit   = best_hit_q;
        nb_idx   = best_idx_q;
        nb_range = best_range_q;
        nb_cnt   = hit_cnt_q;
        if (ret_valid && isect_hit) begin
            nb_cnt = hit_cnt_q + ONE;
            if (!best_hit_q || (isect_range.x < best_range_q.x)) begin
                nb_hit   = 1'b1;
                nb_idx   = ret_tag;
                nb_range = isect_range;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (n_eff == '0) ? DONE : ISSUE;
            ISSUE:   if (issue_last) state_d = DRAIN;
            DRAIN:   if (ret_last) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Ray operands captured on accept.
    always_ff @(posedge sysclk) begin
        if (accept) begin
            orig_q   <= ray_orig;
            inv_q    <= ray_inv_dir;
            trange_q <= ray_t_range;
        end
    end

    // Scan control: box count, issue pointer, valid pipe, hit flag and counter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            issue_idx_q <= '0;
            vld_q       <= '0;
            best_hit_q  <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            vld_q[0] <= (state_q == ISSUE);
            for (int k = 1; k < ISECT_LAT; k++) vld_q[k] <= vld_q[k-1];
            if (accept) begin
                count_q     <= n_eff;
                issue_idx_q <= '0;
                best_hit_q  <= 1'b0;
                hit_cnt_q   <= '0;
            end else begin
                if ((state_q == ISSUE) && !issue_last) issue_idx_q <= issue_idx_q + IDX_W'(1);
                best_hit_q <= nb_hit;
                hit_cnt_q  <= nb_cnt;
            end
        end
    end

    // Box-index tags travelling with the intersect pipeline, and best-hit data.
    always_ff @(posedge sysclk) begin
        tag_q[0] <= issue_idx_q;
        for (int k = 1; k < ISECT_LAT; k++) tag_q[k] <= tag_q[k-1];
        best_idx_q   <= nb_idx;
        best_range_q <= nb_range;
    end

    // Registered result, loaded on the last return (or immediately for an empty scan).
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid     <= 1'b0;
            res_hit       <= 1'b0;
            res_box_idx   <= '0;
            res_range     <= range_default;
            res_hit_count <= '0;
        end else if (accept && (n_eff == '0)) begin
            res_valid     <= 1'b1;
            res_hit       <= 1'b0;
            res_box_idx   <= '0;
            res_range     <= range_default;
            res_hit_count <= '0;
        end else if ((state_q == DRAIN) && ret_last) begin
            res_valid     <= 1'b1;
            res_hit       <= nb_hit;
            res_box_idx   <= nb_hit ? nb_idx : '0;
            res_range     <= nb_hit ? nb_range : range_default;
            res_hit_count <= nb_cnt;
        end else if ((state_q == DONE) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    ray_bbox_scan_table #(
        .NUM_BOXES (NUM_BOXES),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_idx  (box_wr_idx),
        .wr_data (box_wr_data),
        .rd_idx  (issue_idx_q),
        .rd_data (rd_box)
    );

    ray_bbox_intersect u_isect (
        .clk         (sysclk),
        .ray_orig    (orig_q),
        .ray_inv_dir (inv_q),
        .box         (rd_box),
        .prev_range  (trange_q),
        .hit         (isect_hit),
        .range_out   (isect_range)
    );

endmodule

// File: tb/tb_ray_bbox_scan.sv
// Directed bench for ray_bbox_scan with hand-computed nearest-hit results.
module tb_ray_bbox_scan;
    import ray_bbox_scan_pkg::*;

    localparam int   NB  = 8;
    localparam int   LAT = 3;
    localparam int   IW  = 3;
    localparam fix_t B_INF  = 28'sh7FF_FFFF;
    localparam fix_t B_NINF = 28'sh800_0001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ray_valid, ray_ready;
    vec3_t         ray_orig, ray_inv_dir;
    vec2_t         ray_t_range;
    logic [IW:0]   ray_num_boxes;
    logic          box_wr_en, box_wr_ready;
    logic [IW-1:0] box_wr_idx;
    bbox_t         box_wr_data;
    logic          res_valid, res_ready, res_hit;
    logic [IW-1:0] res_box_idx;
    vec2_t         res_range;
    logic [IW:0]   res_hit_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ray_bbox_scan #(.NUM_BOXES(NB), .ISECT_LAT(LAT)) dut (
        .sysclk        (clk),
        .rst_n         (rst_n),
        .ray_valid     (ray_valid),
        .ray_ready     (ray_ready),
        .ray_orig      (ray_orig),
        .ray_inv_dir   (ray_inv_dir),
        .ray_t_range   (ray_t_range),
        .ray_num_boxes (ray_num_boxes),
        .box_wr_en     (box_wr_en),
        .box_wr_idx    (box_wr_idx),
        .box_wr_data   (box_wr_data),
        .box_wr_ready  (box_wr_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_hit       (res_hit),
        .res_box_idx   (res_box_idx),
        .res_range     (res_range),
        .res_hit_count (res_hit_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic fix_t fx(input int v);
        return fix_t'(v * 65536);
    endfunction

    function automatic bbox_t mk_box(input int x0, input int x1, input int y0,
                                     input int y1, input int z0, input int z1);
        bbox_t b;
        b.bmin = '{x: fx(x0), y: fx(y0), z: fx(z0)};
        b.bmax = '{x: fx(x1), y: fx(y1), z: fx(z1)};
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input bbox_t b);
        box_wr_en   = 1'b1;
        box_wr_idx  = IW'(idx);
        box_wr_data = b;
        step();
        box_wr_en = 1'b0;
    endtask

    task automatic set_ray(input int n);
        ray_orig      = '{x: fx(-5), y: fx(5), z: fx(5)};
        ray_inv_dir   = '{x: fx(1), y: B_INF, z: B_INF};
        ray_t_range   = '{x: B_NINF, y: B_INF};
        ray_num_boxes = (IW+1)'(n);
    endtask

    // Offer a ray (optionally with a same-cycle table write) and wait for its result.
    task automatic run_ray(input int n, input logic we, input int widx, input bbox_t wbox,
                           output int lat);
        set_ray(n);
        ray_valid   = 1'b1;
        box_wr_en   = we;
        box_wr_idx  = IW'(widx);
        box_wr_data = wbox;
        step();
        ray_valid = 1'b0;
        box_wr_en = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            step();
            lat++;
        end
        if (!res_valid) chk("res_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic check_res(input string tag, input int lat, input int exp_lat, input logic h,
                             input int idx, input fix_t rx, input fix_t ry, input int cnt);
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".hit"}, 64'(res_hit), 64'(h));
        chk({tag, ".idx"}, 64'(res_box_idx), 64'(idx));
        chk({tag, ".rx"}, 64'(res_range.x), 64'(rx));
        chk({tag, ".ry"}, 64'(res_range.y), 64'(ry));
        chk({tag, ".cnt"}, 64'(res_hit_count), 64'(cnt));
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, ".valid_clr"}, 64'(res_valid), 64'd0);
        chk({tag, ".idle"}, 64'(ray_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    lat;
        logic  seen;
        bbox_t cube, far_x, up_y;
        cube  = mk_box(0, 10, 0, 10, 0, 10);
        far_x = mk_box(20, 30, 0, 10, 0, 10);
        up_y  = mk_box(0, 10, 20, 30, 0, 10);

        rst_n = 1'b0; ray_valid = 1'b0; res_ready = 1'b0; box_wr_en = 1'b0;
        box_wr_idx = '0; box_wr_data = '0; set_ray(0);
        repeat (3) step();
        chk("rst.ray_ready", 64'(ray_ready), 64'd1);
        chk("rst.wr_ready", 64'(box_wr_ready), 64'd1);
        chk("rst.valid", 64'(res_valid), 64'd0);
        chk("rst.hit", 64'(res_hit), 64'd0);
        chk("rst.idx", 64'(res_box_idx), 64'd0);
        chk("rst.rx", 64'(res_range.x), 64'(B_INF));
        chk("rst.ry", 64'(res_range.y), 64'(B_NINF));
        chk("rst.cnt", 64'(res_hit_count), 64'd0);
        rst_n = 1'b1;
        step();

        wr(0, cube); wr(1, far_x); wr(2, up_y);
        run_ray(3, 1'b0, 0, cube, lat);
        check_res("near", lat, 3 + LAT + 1, 1'b1, 0, fx(5), fx(15), 2);
        consume("near");

        wr(0, far_x); wr(1, cube);
        run_ray(3, 1'b0, 0, cube, lat);
        check_res("swap", lat, 3 + LAT + 1, 1'b1, 1, fx(5), fx(15), 2);
        consume("swap");

        wr(0, cube);
        run_ray(3, 1'b0, 0, cube, lat);
        check_res("tie", lat, 3 + LAT + 1, 1'b1, 0, fx(5), fx(15), 2);
        consume("tie");

        run_ray(0, 1'b0, 0, cube, lat);
        check_res("empty", lat, 1, 1'b0, 0, B_INF, B_NINF, 0);
        consume("empty");

        wr(7, mk_box(-3, 10, 0, 10, 0, 10));
        run_ray(15, 1'b0, 0, cube, lat);
        check_res("clamp", lat, NB + LAT + 1, 1'b1, 7, fx(2), fx(15), 3);
        consume("clamp");

        run_ray(3, 1'b0, 0, cube, lat);
        check_res("hold0", lat, 3 + LAT + 1, 1'b1, 0, fx(5), fx(15), 2);
        step();
        wr(2, mk_box(-4, 10, 0, 10, 0, 10));
        repeat (3) step();
        chk("hold.valid", 64'(res_valid), 64'd1);
        chk("hold.idx", 64'(res_box_idx), 64'd0);
        chk("hold.rx", 64'(res_range.x), 64'(fx(5)));
        chk("hold.cnt", 64'(res_hit_count), 64'd2);
        chk("hold.ray_ready", 64'(ray_ready), 64'd0);
        chk("hold.wr_ready", 64'(box_wr_ready), 64'd0);
        consume("hold");
        run_ray(3, 1'b0, 0, cube, lat);
        check_res("nowrite", lat, 3 + LAT + 1, 1'b1, 0, fx(5), fx(15), 2);
        consume("nowrite");

        run_ray(1, 1'b1, 0, mk_box(30, 40, 0, 10, 0, 10), lat);
        check_res("samecyc", lat, 1 + LAT + 1, 1'b1, 0, fx(35), fx(45), 1);
        consume("samecyc");

        set_ray(8);
        ray_valid = 1'b1;
        step();
        ray_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("abort.valid", 64'(res_valid), 64'd0);
        chk("abort.ray_ready", 64'(ray_ready), 64'd1);
        chk("abort.wr_ready", 64'(box_wr_ready), 64'd1);
        chk("abort.hit", 64'(res_hit), 64'd0);
        chk("abort.cnt", 64'(res_hit_count), 64'd0);
        chk("abort.rx", 64'(res_range.x), 64'(B_INF));
        step(); step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (res_valid) seen = 1'b1;
        end
        chk("abort.no_res", 64'(seen), 64'd0);
        run_ray(8, 1'b0, 0, cube, lat);
        check_res("cleared", lat, NB + LAT + 1, 1'b0, 0, B_INF, B_NINF, 0);
        consume("cleared");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ray_bbox_scan.md
Name: ray_bbox_scan

Overview:
Parametrised successor to the single-box path tracer top. It accepts one ray over a valid/ready handshake and streams it against a loadable table of up to NUM_BOXES bounding boxes, one box per cycle, through one pipelined ray_bbox_intersect instance. It reduces the per-box results to the nearest hit and returns it over a valid/ready result handshake. It sits between ray generation and the BVH/shading stages.

Parameters:
NUM_BOXES, 8, box table depth (>=1)
ISECT_LAT, 3, cycles from ray_bbox_intersect input to hit/range_out; must equal the instantiated unit's latency
IDX_W, $clog2(NUM_BOXES) (min 1), derived box-index width; not overridden

Ports:
sysclk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ray_valid  in  1  ray offered
ray_ready  out  1  ray accepted when valid&ready
ray_orig  in  vec3  ray origin (28-bit fixed per component)
ray_inv_dir  in  vec3  reciprocal direction
ray_t_range  in  vec2  initial {x:t_min, y:t_max}, passed as prev_range for every box
ray_num_boxes  in  IDX_W+1  boxes to scan (0..NUM_BOXES)
box_wr_en  in  1  table write strobe
box_wr_idx  in  IDX_W  table write index
box_wr_data  in  bbox  box to store
box_wr_ready  out  1  table writable
res_valid  out  1  result available
res_ready  in  1  result consumed when valid&ready
res_hit  out  1  at least one box hit
res_box_idx  out  IDX_W  index of nearest hit box
res_range  out  vec2  range_out of nearest hit box
res_hit_count  out  IDX_W+1  number of boxes hit

Behaviour:
- Reset: state IDLE; ray_ready=1, box_wr_ready=1, res_valid=0, res_hit=0, res_box_idx=0, res_range=range_default, res_hit_count=0; every table entry = bbox with min=max=point_default; issue/tag pipeline valid bits cleared. Reset mid-scan aborts the scan with no result.
- FSM states: IDLE -> ISSUE on ray accept with sampled count>0; IDLE -> DONE on accept with count==0; ISSUE -> DRAIN after the last box is issued; DRAIN -> DONE when the last tagged result returns; DONE -> IDLE on res_valid&res_ready.
- ray_ready=1 and box_wr_ready=1 only in IDLE. There is no overlap between rays.
- On accept, the block registers ray_orig, ray_inv_dir, ray_t_range and min(ray_num_boxes, NUM_BOXES). It clears best/hit-count.
- Issue: box i enters the intersect unit in cycle A+1+i, where A is the accept cycle. A 1-bit valid plus IDX_W tag shift register of depth ISECT_LAT travels with it.
- Reduction per returning valid result: if hit and (no prior hit or range_out.x < best.x, signed compare), then best := {i, range_out}. Ties keep the lower index (strict <). hit_count increments on every hit.
- Latency: res_valid rises in cycle A+N+ISECT_LAT+1 for N>0, and in cycle A+1 for N=0 (miss, count 0).
- Result outputs are registered and held stable while res_valid&!res_ready. On a miss, res_box_idx=0 and res_range=range_default.
- Table writes are accepted only when box_wr_en&box_wr_ready&(box_wr_idx<NUM_BOXES); all other writes are ignored.
- A write in the same cycle as ray accept takes effect and is seen by the scan.
- Counters have no wrap: hit_count is at most NUM_BOXES and fits IDX_W+1.

Decomposition:
- data_structs package: add scan_state_e {IDLE, ISSUE, DRAIN, DONE}, scan_result struct {hit, box_idx, range, hit_count}, scan_result_default.
- Reuse the existing vec2/vec3/bbox types, range_default, point_default and the INFINITY_28 constants.
- Flops use the codebase FF macro.
- One natural sub-module: bbox_table (NUM_BOXES-entry register file, one write port, one combinational read port).
- ray_bbox_intersect is instantiated unchanged.

Test Plan:
- Ray orig (-5,5,5), inv_dir (1,INF,INF), range (-INF,INF), N=3; table box0 [0,10]^3, box1 x[20,30] y,z[0,10], box2 x[0,10] y[20,30] z[0,10] -> res_hit=1, idx=0, range.x=5, range.y=15, hit_count=2, res_valid at A+3+ISECT_LAT+1.
- Same ray with box0 and box1 swapped -> idx=1, range.x=5; then both boxes identical -> idx=0 (tie keeps lower).
- ray_num_boxes=0 -> res_valid at A+1, res_hit=0, hit_count=0, res_range=range_default; ray_num_boxes=15 with NUM_BOXES=8 scans 8 boxes.
- Hold res_ready=0 for 5 cycles -> outputs stable, ray_ready=0, and a box write (idx 2) attempted in DONE is ignored (verified by the next scan); then res_ready=1 -> IDLE next cycle.
- Write box0 := [30,40]x[0,10]x[0,10] in the same cycle as ray accept -> scan uses the new box, range.x=35.
- Deassert rst_n during ISSUE -> all outputs at reset values immediately, no res_valid afterwards, table cleared (subsequent scan misses).
